// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (optional parity) feeding a small receive FIFO
// Ports: clk, srst_n (synchronous, active-low reset); rx serial line (idle high);
//    rd_en pops the FIFO head shown on rd_data, rd_valid flags a non-empty FIFO;
//    frame_err, parity_err, overrun are one-cycle error pulses; busy is high
//    whenever the receiver is not idle.
module uart_rx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 srst_n,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic ODD = PARITY_ODD != 0;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
   state_t state, state_n;
   logic sync1, rx_s, rx_q;
   logic [TW-1:0] timer;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic par_bad;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic tick_half, tick_full, stop_tick, push, pop, full, wr;
   assign tick_half = timer == HALF;
   assign tick_full = timer == LAST;
   assign stop_tick = state == STOP && tick_full;
   assign push = stop_tick && rx_s && !par_bad;
   assign pop = rd_en && rd_valid;
   // full when the pointers differ only in their wrap bit
   assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
   // a full FIFO still takes the word if the head leaves in the same cycle
   assign wr = push && (!full || pop);
   assign rd_valid = wr_ptr != rd_ptr;
   assign rd_data = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!srst_n) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (rx_q && !rx_s) state_n = START;
         START:     if (tick_half) state_n = rx_s ? IDLE : DATA;
         DATA:      if (tick_full && bit_cnt == LAST_BIT) state_n = PARITY_EN != 0 ? PARITY : STOP;
         PARITY:    if (tick_full) state_n = STOP;
         STOP:      if (tick_full) state_n = rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         sync1      <= 1'b1;
         rx_s       <= 1'b1;
         rx_q       <= 1'b1;
         timer      <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         sync1      <= rx;
         rx_s       <= sync1;
         rx_q       <= rx_s;
         // START times half a bit to land on mid-bit; later states time whole bits
         timer      <= (state == IDLE || state == WAIT_HIGH || (state == START ? tick_half : tick_full)) ? '0 : timer + TW'(1);
         bit_cnt    <= state == DATA ? bit_cnt + BW'(tick_full) : '0;
         if (state == DATA && tick_full) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         par_bad    <= (state == PARITY && tick_full) ? ((^shreg ^ rx_s) != ODD) : (state == IDLE ? 1'b0 : par_bad);
         frame_err  <= stop_tick && !rx_s;
         parity_err <= stop_tick && par_bad;
         overrun    <= push && full && !pop;
         if (wr) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (srst_n && wr) mem[wr_ptr[AW-1:0]] <= shreg;
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, 8, data bits per frame; legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 4.
REQ-003 Parameter PARITY_EN, 0, 1 = one parity bit follows data.
REQ-004 Parameter PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 Parameter FIFO_DEPTH, 4, receive buffer entries; power of 2, >= 2.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 srst_n  input  1  reset, synchronous, active-low.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 rd_en  input  1  pop request for FIFO head.
REQ-010 rd_data  output  DATA_BITS  FIFO head word; 0 when empty.
REQ-011 rd_valid  output  1  FIFO non-empty.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 parity_err  output  1  one-cycle pulse: parity mismatch.
REQ-014 overrun  output  1  one-cycle pulse: good frame dropped, FIFO full.
REQ-015 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-016 rx SHALL pass a 2-flop synchronizer (rx_s); both flops reset to 1, so reset never fakes a start edge.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE: falling edge of rx_s (previous 1, current 0) -> START, bit-timer cleared.
REQ-019 START: after CLKS_PER_BIT/2 cycles sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no error pulse).
REQ-020 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), LSB first, DATA_BITS samples; then PARITY if PARITY_EN else STOP.
REQ-021 PARITY: one mid-bit sample; error if XOR(data, parity bit) != PARITY_ODD.
REQ-022 STOP: one mid-bit sample; 1 -> frame complete, FSM -> IDLE same edge; 0 -> frame_err pulse, word discarded, -> WAIT_HIGH.
REQ-023 WAIT_HIGH: remain until rx_s = 1, then -> IDLE; no start detection meanwhile.
REQ-024 Parity error on a frame with good stop bit: parity_err pulse, word discarded, no push; if stop also bad, both error pulses in the stop-sample cycle.
REQ-025 Error pulses SHALL assert in the cycle after the stop-bit sample edge, exactly one cycle wide.
REQ-026 Good frame: word pushed on the stop-sample edge; rd_valid high from the next cycle if FIFO was empty.
REQ-027 Push while full and no same-cycle pop: word dropped, overrun pulse, FIFO contents unchanged.
REQ-028 Push while full with same-cycle pop (rd_en & rd_valid): push accepted, no overrun.
REQ-029 rd_en & rd_valid: head removed, rd_data shows next entry next cycle; rd_en while empty ignored, no pointer change.
REQ-030 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSBs differ, low bits equal.
REQ-031 Bit-timer width SHALL be clog2(CLKS_PER_BIT); bit counter width clog2(DATA_BITS+1).

Reset
REQ-032 srst_n low at any clk edge SHALL force: FSM IDLE, timers/counters 0, shift register 0, FIFO empty, synchronizer 1.
REQ-033 Reset outputs: rd_valid 0, rd_data 0, frame_err 0, parity_err 0, overrun 0, busy 0.
REQ-034 Reset mid-frame SHALL abort the frame silently (no push, no error pulse); reception restarts on the next falling edge after release.

Verification (DATA_BITS=8, CLKS_PER_BIT=16, FIFO_DEPTH=4 unless stated)
REQ-035 Send 0xA5, 8N1 -> rd_valid rises, rd_data = 0xA5; rd_en one cycle -> rd_valid 0, rd_data 0.
REQ-036 PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> 0x07 pushed; parity 0 -> parity_err one pulse, FIFO stays empty.
REQ-037 Send 0x3C with stop bit 0, line held low 40 cycles -> frame_err one pulse, no push, busy high until line returns high.
REQ-038 Send 5 frames 0x01..0x05, no reads -> FIFO holds 0x01..0x04, overrun pulses once on frame 5; pop order 0x01..0x04.
REQ-039 rx low pulse of 6 cycles -> START then IDLE, no push, no error pulse.
REQ-040 srst_n low 1 cycle during data bit 4 -> all outputs at reset values; next full 0x5A frame received correctly.
